// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access size codes, FSM encoding
// and the byte-lane helpers used when building a data-memory request.
package memory_access_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2
  } mem_state_e;

  // Big-endian lanes: byte offset 0 lives in be[3] / bits [31:24].
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b1000 >> off;
      SZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    logic bad;
    case (size)
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo[1:0];
      SZ_DBL:  bad = |lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/memory_access_stage_load_data_aligner.sv
// Picks the addressed byte/half out of a big-endian read word and zero- or
// sign-extends it to 32 bits; word and double beats pass through unchanged.
module load_data_aligner
  import memory_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  always_comb begin
    result = rdata;
    case (size)
      SZ_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: turns the EX bundle into word-aligned req/ack data-memory
// beats (two for ldd/std), extends load data and emits one writeback beat per result.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  // Upstream handshake: a bundle transfers on a rising edge where in_valid &&
  // in_ready; in_ready is high exactly while the FSM sits in IDLE.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_access_size,
  input  logic              mem_access_signed,
  input  logic              reg_write,
  input  logic [4:0]        rd,
  input  logic [ADDR_W-1:0] ex_result,
  input  logic [63:0]       store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              align_trap,
  output logic              bus_error,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W:0] TMO_LIM = (CNT_W + 1)'(ACK_TIMEOUT);

  mem_state_e       state;
  logic             r_load;
  logic [1:0]       r_size;
  logic             r_signed;
  logic             r_reg_write;
  logic [4:0]       r_rd;
  logic [1:0]       r_off;
  logic [31:0]      r_sdata_lo;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W:0]   cnt_nxt;
  logic             in_mem;
  logic             in_bad_align;
  logic [31:0]      load_ext;
  logic             last_beat;

  assign in_ready     = (state == ST_IDLE);
  assign dbg_state    = state;
  assign in_mem       = mem_read | mem_write;
  assign in_bad_align = misaligned(mem_access_size, ex_result[2:0]);
  assign cnt_nxt      = {1'b0, tmo_cnt} + (CNT_W + 1)'(1);
  assign last_beat    = !(state == ST_ACC0 && r_size == SZ_DBL);

  load_data_aligner u_aligner (
    .rdata    (dmem_rdata),
    .offset   (r_off),
    .size     (r_size),
    .sign_ext (r_signed),
    .result   (load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      r_load       <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_off        <= '0;
      r_sdata_lo   <= '0;
      tmo_cnt      <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      align_trap   <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      align_trap <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!in_mem) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= reg_write;
              wb_rd        <= rd;
              wb_data      <= 32'(ex_result);
            end else if (in_bad_align) begin
              align_trap <= 1'b1;
            end else begin
              // A load with the write bit also set is still a load.
              state       <= ST_ACC0;
              r_load      <= mem_read;
              r_size      <= mem_access_size;
              r_signed    <= mem_access_signed;
              r_reg_write <= reg_write;
              r_rd        <= rd;
              r_off       <= ex_result[1:0];
              r_sdata_lo  <= store_data[31:0];
              tmo_cnt     <= '0;
              dmem_req    <= 1'b1;
              dmem_we     <= ~mem_read;
              dmem_addr   <= {ex_result[ADDR_W-1:2], 2'b00};
              dmem_be     <= byte_enables(mem_access_size, ex_result[1:0]);
              dmem_wdata  <= (mem_access_size == SZ_DBL) ? store_data[63:32]
                                                         : lane_wdata(mem_access_size, store_data[31:0]);
            end
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (dmem_ack) begin
            tmo_cnt <= '0;
            if (r_load) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= r_reg_write;
              wb_rd        <= (r_size == SZ_DBL) ? {r_rd[4:1], state == ST_ACC1} : r_rd;
              wb_data      <= load_ext;
            end else if (last_beat) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_rd        <= r_rd;
              wb_data      <= '0;
            end
            if (!last_beat) begin
              // Second word of ldd/std follows immediately at addr+4.
              state      <= ST_ACC1;
              dmem_addr  <= dmem_addr + ADDR_W'(4);
              dmem_wdata <= r_sdata_lo;
            end else begin
              state    <= ST_IDLE;
              dmem_req <= 1'b0;
              dmem_we  <= 1'b0;
            end
          end else if (ACK_TIMEOUT != 0 && cnt_nxt == TMO_LIM) begin
            state     <= ST_IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            bus_error <= 1'b1;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= cnt_nxt[CNT_W-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
